// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: round-robin sharing of the single reg_file command port among NUM_REQ requesters.
// Optional macro REG_ARB_HAZARD_EN adds a dirty/owner scoreboard that holds back hazardous reads.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_port_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_cmd,
  input  logic [4*NUM_REQ-1:0]          i_req_reg,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  input  logic [NUM_REQ-1:0]            i_rsp_ready,
  output logic [3:0]                    o_rf_reg,
  output logic [DATA_WIDTH-1:0]         o_rf_data,
  output logic [1:0]                    o_rf_cmd,
  output logic                          o_rf_valid,
  input  logic                          i_rf_ready,
  input  logic [DATA_WIDTH-1:0]         i_rf_data,
  input  logic                          i_rf_res_valid,
  output logic                          o_rf_res_ready
);
  localparam int unsigned IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_grant;
  logic [IW-1:0]         r_last_grant;
  logic [IW-1:0]         w_grant_idx;
  logic                  w_grant_found;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_eligible;
  int unsigned           w_idx;
  logic [1:0]            w_cmd  [NUM_REQ];
  logic [3:0]            w_reg  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [1:0]            w_sel_cmd;
  logic [3:0]            w_sel_reg;
  logic [DATA_WIDTH-1:0] w_sel_data;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_split
    assign w_cmd[k]  = i_req_cmd[2*k +: 2];
    assign w_reg[k]  = i_req_reg[4*k +: 4];
    assign w_data[k] = i_req_data[DATA_WIDTH*k +: DATA_WIDTH];
  end

`ifdef REG_ARB_HAZARD_EN
  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_MARKD = 2'd2;
  localparam logic [1:0] CMD_CHECK = 2'd3;

  logic [7:0]      r_dirty;
  logic [7:0][1:0] r_owner;

  // A read of a register marked dirty by another requester is held back.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_elig
    logic w_hzd;
    assign w_hzd = (w_cmd[k] == CMD_READ || w_cmd[k] == CMD_CHECK) && !w_reg[k][3] &&
                   r_dirty[w_reg[k][2:0]] && (r_owner[w_reg[k][2:0]] != 2'(k));
    assign w_eligible[k] = i_req_valid[k] & ~w_hzd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dirty <= '0;
      r_owner <= '0;
    end else if (w_accept && !w_sel_reg[3]) begin
      if (w_sel_cmd == CMD_MARKD) begin
        r_dirty[w_sel_reg[2:0]] <= 1'b1;
        r_owner[w_sel_reg[2:0]] <= 2'(w_grant_idx);
      end else if (w_sel_cmd == CMD_WRITE) begin
        r_dirty[w_sel_reg[2:0]] <= 1'b0;
      end
    end
  end
`else
  assign w_eligible = i_req_valid;
`endif

  // Round-robin: first eligible index after the last completed grant.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_idx         = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_idx = 32'(r_last_grant) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_grant_found && w_eligible[w_idx[IW-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_idx[IW-1:0];
      end
    end
  end

  assign w_sel_cmd  = w_cmd[w_grant_idx];
  assign w_sel_reg  = w_reg[w_grant_idx];
  assign w_sel_data = w_data[w_grant_idx];
  assign w_accept   = (r_state == S_IDLE) && w_grant_found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_found)        w_state_nxt = S_ISSUE;
      S_ISSUE:  if (i_rf_ready)           w_state_nxt = S_WAIT;
      S_WAIT:   if (i_rf_res_valid)       w_state_nxt = S_RETURN;
      S_RETURN: if (i_rsp_ready[r_grant]) w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // The accept pulse is combinational so a command is taken in the cycle it is granted.
  always_comb begin
    o_req_ready    = '0;
    o_rsp_valid    = '0;
    o_rf_valid     = 1'b0;
    o_rf_res_ready = 1'b0;
    case (r_state)
      S_IDLE:   o_req_ready[w_grant_idx] = reset & w_grant_found;
      S_ISSUE:  o_rf_valid               = 1'b1;
      S_WAIT:   o_rf_res_ready           = 1'b1;
      S_RETURN: o_rsp_valid[r_grant]     = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant      <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      o_rf_cmd     <= '0;
      o_rf_reg     <= '0;
      o_rf_data    <= '0;
      o_rsp_data   <= '0;
    end else begin
      if (w_accept) begin
        r_grant   <= w_grant_idx;
        o_rf_cmd  <= w_sel_cmd;
        o_rf_reg  <= w_sel_reg;
        o_rf_data <= w_sel_data;
      end
      if (r_state == S_WAIT && i_rf_res_valid) o_rsp_data <= i_rf_data;
      if (r_state == S_RETURN && i_rsp_ready[r_grant]) r_last_grant <= r_grant;
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter: a small reg_file model answers commands and a
// queue of expected responses is filled at each grant and drained at each response.
module tb_reg_port_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned DW = 32;
  localparam logic [1:0] C_RD = 2'd0, C_WR = 2'd1, C_MK = 2'd2, C_CK = 2'd3;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    i_req_valid;
  logic [2*NR-1:0]  i_req_cmd;
  logic [4*NR-1:0]  i_req_reg;
  logic [DW*NR-1:0] i_req_data;
  logic [NR-1:0]    o_req_ready;
  logic [NR-1:0]    o_rsp_valid;
  logic [DW-1:0]    o_rsp_data;
  logic [NR-1:0]    i_rsp_ready;
  logic [3:0]       o_rf_reg;
  logic [DW-1:0]    o_rf_data;
  logic [1:0]       o_rf_cmd;
  logic             o_rf_valid;
  logic             i_rf_ready;
  logic [DW-1:0]    i_rf_data;
  logic             i_rf_res_valid;
  logic             o_rf_res_ready;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   grant_cyc, rsp_cyc, gk;
  exp_t exp_q[$];

  reg_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_cmd(i_req_cmd), .i_req_reg(i_req_reg),
    .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data), .i_rsp_ready(i_rsp_ready), .o_rf_reg(o_rf_reg),
    .o_rf_data(o_rf_data), .o_rf_cmd(o_rf_cmd), .o_rf_valid(o_rf_valid),
    .i_rf_ready(i_rf_ready), .i_rf_data(i_rf_data), .i_rf_res_valid(i_rf_res_valid),
    .o_rf_res_ready(o_rf_res_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reg_file reply value: depends on every command field so misrouting shows up.
  function automatic logic [31:0] rf_fn(logic [1:0] c, logic [3:0] r, logic [31:0] d);
    return 32'h1234 ^ d ^ ({28'h0, r} << 8) ^ ({30'h0, c} << 16);
  endfunction

  // reg_file model: result one cycle after the command handshake, held until accepted.
  logic        rf_pend;
  logic [31:0] rf_val;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_pend        <= 1'b0;
      rf_val         <= '0;
      i_rf_res_valid <= 1'b0;
      i_rf_data      <= '0;
    end else begin
      if (o_rf_valid && i_rf_ready) begin
        rf_pend <= 1'b1;
        rf_val  <= rf_fn(o_rf_cmd, o_rf_reg, o_rf_data);
      end
      if (rf_pend && !i_rf_res_valid) begin
        i_rf_res_valid <= 1'b1;
        i_rf_data      <= rf_val;
        rf_pend        <= 1'b0;
      end else if (i_rf_res_valid && o_rf_res_ready) begin
        i_rf_res_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [1:0] c,
                         input logic [3:0] r, input logic [31:0] d);
    i_req_valid[k]        = v;
    i_req_cmd[2*k +: 2]   = c;
    i_req_reg[4*k +: 4]   = r;
    i_req_data[DW*k +: DW] = d;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp_oh);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (o_req_ready == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(o_req_ready), 64'(exp_oh));
    gk        = o_req_ready[1] ? 1 : 0;
    e.idx     = 2'(gk);
    e.data    = rf_fn(i_req_cmd[2*gk +: 2], i_req_reg[4*gk +: 4], i_req_data[DW*gk +: DW]);
    exp_q.push_back(e);
    grant_cyc = cyc;
  endtask

  task automatic wait_rsp(input string tag);
    int         n = 0;
    exp_t       e;
    logic [1:0] oh;
    @(negedge clk);
    while (o_rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    oh = 2'b01 << e.idx;
    chk({tag, "_vld"}, 64'(o_rsp_valid), 64'(oh));
    chk({tag, "_data"}, 64'(o_rsp_data), 64'(e.data));
    chk({tag, "_excl"}, 64'(o_rf_valid), 64'(0));
    rsp_cyc = cyc;
  endtask

  task automatic drop(input int k);
    @(posedge clk); #1;
    i_req_valid[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] t4_data;
    int n;
    reset = 1'b0;
    i_req_valid = '0; i_req_cmd = '0; i_req_reg = '0; i_req_data = '0;
    i_rsp_ready = 2'b11;
    i_rf_ready  = 1'b1;

    // 1: reset state, then single READ with minimum latency
    repeat (3) @(negedge clk);
    chk("rst_ctl", {o_req_ready, o_rsp_valid, o_rf_valid, o_rf_res_ready, o_rf_reg, o_rf_cmd}, 0);
    chk("rst_data", {o_rsp_data, o_rf_data}, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 set_req(0, 1'b1, C_RD, 4'd0, 32'h0);
    wait_grant("t1_grant", 2'b01);
    drop(0);
    @(negedge clk);
    chk("t1_issue", {o_rf_valid, o_rf_reg, o_rf_cmd}, {1'b1, 4'd0, C_RD});
    wait_rsp("t1_rsp");
    chk("t1_value", 64'(o_rsp_data), 64'(32'h1234));
    chk("t1_lat", 64'(rsp_cyc - grant_cyc), 64'(4));

    // 2: two held requesters alternate; last grant was 0 so requester 1 leads
    @(posedge clk); #1;
    set_req(0, 1'b1, C_RD, 4'd2, 32'h0);
    set_req(1, 1'b1, C_CK, 4'd12, 32'hA5A5_0000);
    for (int t = 0; t < 4; t++) begin
      wait_grant("t2_grant", (t % 2 == 0) ? 2'b10 : 2'b01);
      wait_rsp("t2_rsp");
    end
    @(posedge clk); #1 i_req_valid = '0;

    // 3: reg_file stalls the command for 3 cycles
    i_rf_ready = 1'b0;
    set_req(0, 1'b1, C_WR, 4'd5, 32'hDEAD_BEEF);
    wait_grant("t3_grant", 2'b01);
    drop(0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold", {o_rf_valid, o_rf_reg, o_rf_cmd, o_rf_data}, {1'b1, 4'd5, C_WR, 32'hDEAD_BEEF});
    end
    @(posedge clk); #1 i_rf_ready = 1'b1;
    wait_rsp("t3_rsp");
    chk("t3_lat", 64'(rsp_cyc - grant_cyc), 64'(7));

    // 4: granted requester withholds rsp_ready; other ready is ignored and no new grant
    i_rsp_ready = 2'b01;
    set_req(1, 1'b1, C_MK, 4'd9, 32'h55);
    t4_data = rf_fn(C_MK, 4'd9, 32'h55);
    wait_grant("t4_grant", 2'b10);
    drop(1);
    set_req(0, 1'b1, C_RD, 4'd7, 32'h0);
    wait_rsp("t4_rsp");
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold", {o_rsp_valid, o_rsp_data, o_req_ready, o_rf_valid}, {2'b10, t4_data, 2'b00, 1'b0});
    end
    @(posedge clk); #1 i_rsp_ready = 2'b11;
    wait_grant("t4_next", 2'b01);
    drop(0);
    wait_rsp("t4_next_rsp");

    // 5: reset during WAIT abandons the transaction and restores requester 0 priority
    @(posedge clk); #1 set_req(0, 1'b1, C_RD, 4'd1, 32'h0);
    wait_grant("t5_grant", 2'b01);
    drop(0);
    n = 0;
    @(negedge clk);
    while (!o_rf_res_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t5_inwait", 64'(o_rf_res_ready), 64'(1));
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_ctl", {o_req_ready, o_rsp_valid, o_rf_valid, o_rf_res_ready, o_rf_reg, o_rf_cmd}, 0);
    chk("t5_rst_data", {o_rsp_data, o_rf_data}, 0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t5_norsp", {o_rsp_valid, o_rf_valid}, 0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, C_RD, 4'd3, 32'h0);
    set_req(1, 1'b1, C_RD, 4'd4, 32'h0);
    wait_grant("t5_first", 2'b01);
    drop(0);
    wait_rsp("t5_first_rsp");
    wait_grant("t5_second", 2'b10);
    drop(1);
    wait_rsp("t5_second_rsp");

    // 6: MARKD by requester 1, then competing READ (req0) and WRITE (req1) of the same reg
    @(posedge clk); #1 set_req(1, 1'b1, C_MK, 4'd3, 32'h0);
    wait_grant("t6_markd", 2'b10);
    drop(1);
    wait_rsp("t6_markd_rsp");
    @(posedge clk); #1;
    set_req(0, 1'b1, C_RD, 4'd3, 32'h0);
    set_req(1, 1'b1, C_WR, 4'd3, 32'h77);
`ifdef REG_ARB_HAZARD_EN
    wait_grant("t6_first", 2'b10);
    drop(1);
    wait_rsp("t6_first_rsp");
    wait_grant("t6_second", 2'b01);
    drop(0);
    wait_rsp("t6_second_rsp");
`else
    wait_grant("t6_first", 2'b01);
    drop(0);
    wait_rsp("t6_first_rsp");
    wait_grant("t6_second", 2'b10);
    drop(1);
    wait_rsp("t6_second_rsp");
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
